// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg: shared state type, segment constants and the hex glyph table
// for the multiplexed 7-segment scanner.
package seven_seg_scanner_pkg;
    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_e;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int SEG_DP = 7;
    // Active-high abcdefg glyphs, entry n at bits [7n +: 7]
    localparam logic [16*7-1:0] HEX_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seven_seg_scanner_hex.sv
// hex_to_seven_seg: combinational 4-bit nibble to active-high abcdefg glyph.
module hex_to_seven_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);
    assign glyph_o = HEX_GLYPHS[int'(nibble_i) * 7 +: 7];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 7-segment driver with dead-time and
// frame-aligned double buffering. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 100,
    parameter int DIGITS       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            io_seg,
    output logic [DIGITS-1:0]     io_sel,
    output logic                  frame_start,
    output logic                  pending
);
    localparam int SLOT = CLK_HZ / DIGIT_HZ;
    localparam int CW = $clog2(SLOT);
    localparam int IW = $clog2(DIGITS);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [4*DIGITS-1:0] buf_val_q, act_val_q;
    logic [DIGITS-1:0] buf_dp_q, act_dp_q, sel_q, sel_d;
    logic [7:0] seg_q, seg_d;
    logic fs_q, pend_q, pend_d, boundary, driving;
    logic [3:0] nibble;
    logic [6:0] glyph, shown;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (!enable) begin
            state_d = BLANK;
            cnt_d = '0;
            idx_d = '0;
        end else if (state_q == BLANK) begin
            if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = DRIVE;
        end else if (cnt_q == CW'(SLOT - 1)) begin
            state_d = BLANK;
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end
    // The only cycle with BLANK/slot 0/digit 0 while enabled is a frame boundary,
    // which covers both the wrap and the first cycle after enable or reset release.
    assign boundary = enable && state_q == BLANK && cnt_q == '0 && idx_q == '0;
    assign pend_d = load | (pend_q & ~boundary);
    assign driving = enable && state_q == DRIVE;
    assign nibble = act_val_q[4*idx_q +: 4];
    hex_to_seven_seg u_hex (
        .nibble_i (nibble),
        .glyph_o  (glyph)
    );
`ifdef SEVEN_SEG_LZB_EN
    logic [DIGITS-1:0] lead_zero;
    logic run;
    always_comb begin
        run = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run & (act_val_q[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end
    assign shown = (idx_q != '0 && lead_zero[idx_q]) ? 7'h00 : glyph;
`else
    assign shown = glyph;
`endif
    assign seg_d = driving ? ~{act_dp_q[idx_q], shown} : SEG_OFF;
    assign sel_d = driving ? ~(DIGITS'(1) << idx_q) : '1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_OFF;
            sel_q     <= '1;
            fs_q      <= 1'b0;
            pend_q    <= 1'b0;
            buf_val_q <= '0;
            buf_dp_q  <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fs_q    <= boundary;
            pend_q  <= pend_d;
            if (load) begin
                buf_val_q <= value;
                buf_dp_q  <= dp;
            end
            if (boundary && pend_q) begin
                act_val_q <= buf_val_q;
                act_dp_q  <= buf_dp_q;
            end
        end
    end
    assign io_seg = seg_q;
    assign io_sel = sel_q;
    assign frame_start = fs_q;
    assign pending = pend_q;
endmodule
